bitty_core_p: RTL and testbench

Parametrised next-generation bitty execution core. DATA_W, register count and immediate width are configurable. Adds reg-imm/reg-reg formats, shift and compare ops, a busy/illegal status and back-to-back run acceptance. Sits between the instruction source (e.g. a fetch unit) and the debug/IO fabric; executes one instruction per run handshake into an internal register file.

---
 rtl/bitty_p_pkg.sv | 55 +++++
 rtl/bitty_alu_p.sv | 46 ++++
 rtl/bitty_core_p.sv | 123 ++++++++++++
 tb/tb_bitty_core_p.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_p_pkg.sv
// Shared encodings and field-layout helpers for the parametrised bitty core.
package bitty_p_pkg;

  typedef enum logic [1:0] {
    FMT_RR  = 2'b00,
    FMT_RI  = 2'b01,
    FMT_RS2 = 2'b10,
    FMT_RS3 = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_S = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  localparam int FMT_LSB = 0;
  localparam int OP_LSB  = 2;
  localparam int RSV_BIT = 5;
  localparam int SRC_LSB = 6;

  function automatic int ridx_w(int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  function automatic int src_w(int num_regs, int imm_w);
    return (ridx_w(num_regs) > imm_w) ? ridx_w(num_regs) : imm_w;
  endfunction

  function automatic int instr_w(int num_regs, int imm_w);
    return SRC_LSB + src_w(num_regs, imm_w) + ridx_w(num_regs);
  endfunction

  // Both reserved formats have the upper fmt bit set.
  function automatic logic fmt_illegal(logic [1:0] fmt);
    return fmt[1];
  endfunction

endpackage

// File: rtl/bitty_alu_p.sv
// Combinational bitty ALU: result plus carry/borrow/shifted-out bit.
module bitty_alu_p
  import bitty_p_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              co
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  logic [DATA_W:0] sum, dif, shl, shr;

  assign sh  = b[SH_W-1:0];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // One spare bit on the far side catches the last bit shifted out.
  assign shl = {1'b0, a} << sh;
  assign shr = {a, 1'b0} >> sh;

  always_comb begin
    y  = '0;
    co = 1'b0;
    case (op)
      OP_ADD: begin y = sum[DATA_W-1:0]; co = sum[DATA_W]; end
      OP_SUB: begin y = dif[DATA_W-1:0]; co = dif[DATA_W]; end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin y = shl[DATA_W-1:0]; co = shl[DATA_W]; end
      OP_SHR: begin y = shr[DATA_W:1];   co = shr[0];      end
      OP_CMP: begin
        if (a == b)     y = DATA_W'(CMP_EQ);
        else if (a > b) y = DATA_W'(CMP_GT);
        else            y = DATA_W'(CMP_LT);
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitty_core_p.sv
// Parametrised bitty execution core: 4-state run/load/exec/write-back FSM.
// Optional flags output enabled by defining BITTY_FLAGS_EN.
module bitty_core_p
  import bitty_p_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IMM_W    = 7,
  localparam int RIDX_W  = ridx_w(NUM_REGS),
  localparam int INSTR_W = instr_w(NUM_REGS, IMM_W)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [INSTR_W-1:0]           instruction,
  output logic                         busy,
  output logic                         done,
  output logic                         illegal,
  output logic [1:0]                   flags,
  output logic [NUM_REGS*DATA_W-1:0]   reg_dbg
);

  state_e state, state_nx;
  logic   ld_ir;

  logic [INSTR_W-1:0]               ir;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic [DATA_W-1:0]                s_q, c_q, b_op, alu_y;
  logic                             alu_co;

  logic [1:0]        fmt;
  op_e               op;
  logic [RIDX_W-1:0] rx, ry;
  logic [IMM_W-1:0]  imm;
  logic              bad;
  logic              unused_rsv;

  assign fmt        = ir[FMT_LSB +: 2];
  assign op         = op_e'(ir[OP_LSB +: 3]);
  assign rx         = ir[INSTR_W-1 -: RIDX_W];
  assign ry         = ir[SRC_LSB +: RIDX_W];
  assign imm        = ir[SRC_LSB +: IMM_W];
  assign bad        = fmt_illegal(fmt);
  assign unused_rsv = ir[RSV_BIT];

  assign b_op = (fmt == FMT_RR) ? regs[ry] : DATA_W'(imm);

  bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
    .op (op),
    .a  (s_q),
    .b  (b_op),
    .y  (alu_y),
    .co (alu_co)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_ir    = 1'b0;
    case (state)
      IDLE: if (run) begin
        state_nx = LOAD_S;
        ld_ir    = 1'b1;
      end
      LOAD_S:  state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Illegal formats still flow through EXEC; only the commit is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir      <= '0;
      regs    <= '0;
      s_q     <= '0;
      c_q     <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (ld_ir)           ir  <= instruction;
      if (state == LOAD_S) s_q <= regs[rx];
      if (state == EXEC)   c_q <= alu_y;
      if (state == WB) begin
        done    <= 1'b1;
        illegal <= bad;
        if (!bad) regs[rx] <= c_q;
      end
    end
  end

`ifdef BITTY_FLAGS_EN
  logic       c_co;
  logic [1:0] flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_co    <= 1'b0;
      flags_q <= 2'b00;
    end else begin
      if (state == EXEC)        c_co    <= alu_co;
      if (state == WB && !bad)  flags_q <= {c_co, (c_q == '0)};
    end
  end

  assign flags = flags_q;
`else
  logic unused_co;
  assign unused_co = alu_co;
  assign flags     = 2'b00;
`endif

  assign busy    = (state != IDLE);
  assign reg_dbg = regs;

endmodule

// File: tb/tb_bitty_core_p.sv
// Scoreboard bench for bitty_core_p at default parameters.
module tb_bitty_core_p;

  localparam int DW = 16;
  localparam int NR = 8;
`ifdef BITTY_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, run;
  logic [15:0]      instruction;
  logic             busy, done, illegal;
  logic [1:0]       flags;
  logic [NR*DW-1:0] reg_dbg;

  bitty_core_p dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .flags       (flags),
    .reg_dbg     (reg_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR*DW-1:0] regs;
    logic             ill;
    logic [1:0]       fl;
    int               due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_r[NR];
  logic [1:0]  m_fl;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [NR*DW-1:0] snap();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_r[i];
    return v;
  endfunction

  // Reference: Rx <= Rx op B with plain integer arithmetic.
  task automatic predict(input logic [15:0] ins, input int due);
    exp_t   e;
    int     fmt, op, src, rx, sh;
    longint a, b, r;
    logic   cy;
    fmt = int'(ins[1:0]);
    op  = int'(ins[4:2]);
    src = int'(ins >> 6) & 'h7F;
    rx  = int'(ins[15:13]);
    a   = longint'(m_r[rx]);
    b   = (fmt == 0) ? longint'(m_r[src % NR]) : longint'(src);
    sh  = int'(b % DW);
    cy  = 1'b0;
    case (op)
      0: begin r = a + b; cy = (r >= 65536); end
      1: begin r = a - b; cy = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << sh; cy = (sh != 0) ? 1'((a >> (DW - sh)) & 1) : 1'b0; end
      6: begin r = a >> sh; cy = (sh != 0) ? 1'((a >> (sh - 1)) & 1) : 1'b0; end
      default: r = (a == b) ? 0 : (a > b) ? 1 : 2;
    endcase
    r = r & 'hFFFF;
    if (fmt < 2) begin
      m_r[rx] = 16'(r);
      m_fl    = {cy, (r == 0)};
    end
    e.regs = snap();
    e.ill  = (fmt >= 2);
    e.fl   = FL ? m_fl : 2'b00;
    e.due  = due;
    q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_r[i] = '0;
    m_fl = 2'b00;
    q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  // mode: 0 run low while waiting, 1 run held high, 2 run random.
  task automatic issue(input logic [15:0] ins, input int mode);
    int g = 0;
    while (busy && g < 50) begin
      run = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      instruction = 16'($urandom);
      @(negedge clk);
      g++;
    end
    if (busy) check("idle_timeout", busy, 0);
    run = 1'b1;
    instruction = ins;
    predict(ins, cyc + 4);
    @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    run = 1'b0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: each done pulse pops one expectation and checks timing and state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
      end else if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.due);
          check("reg_dbg", reg_dbg, e.regs);
          check("illegal", illegal, e.ill);
          check("flags", flags, e.fl);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        check("missing_done", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] ins;
    reset = 1'b1;
    run = 1'b0;
    instruction = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_regs", reg_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_flags", flags, 0);
    reset = 1'b0;
    @(negedge clk);

    // R1 += 5, with busy profile
    issue(16'h2141, 0);
    run = 1'b0;
    check("busy_c1", busy, 1);
    @(negedge clk); check("busy_c2", busy, 1);
    @(negedge clk); check("busy_c3", busy, 1);
    @(negedge clk); check("busy_c4", busy, 0);
    @(negedge clk); check("done_width", done, 0);

    issue(16'h4040, 0);
    issue(16'h6045, 0);
    issue(16'h225D, 0);
    // run held: one instruction every 4 cycles
    issue(16'h8040, 1);
    issue(16'hA0D5, 1);
    issue(16'h4094, 1);
    issue(16'h2142, 1);
    drain();

    // run while busy is ignored
    issue(16'h2141, 0);
    run = 1'b1;
    instruction = 16'h4040;
    @(negedge clk);
    instruction = 16'h6045;
    @(negedge clk);
    run = 1'b0;
    drain();

    // reset during EXEC aborts
    run = 1'b1;
    instruction = 16'h2141;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("abort_regs", reg_dbg, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_flags", flags, 0);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    for (int n = 0; n < 300; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ins[1] = 1'b0;
      issue(ins, 2);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
